// File: rtl/apb_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// registered response pulses and an optional PREADY timeout abort.
module apb_master_arb #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              RESETn,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [2*AW-1:0]   req_addr,
    input  logic [2*DW-1:0]   req_wdata,
    output logic [1:0]        req_grant,
    output logic [1:0]        rsp_valid,
    output logic              rsp_err,
    output logic [DW-1:0]     rsp_rdata,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AW-1:0]     PADDR,
    output logic [DW-1:0]     PWDATA,
    input  logic [DW-1:0]     PRDATA,
    input  logic              PREADY
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
    localparam logic          TO_EN    = (TIMEOUT != 0);

    logic [1:0]    r_state;
    logic          r_last;
    logic          r_owner;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_grant;
    logic [1:0]    r_rspValid;
    logic          r_rspErr;
    logic [DW-1:0] r_rdata;
    logic          r_psel;
    logic          r_penable;
    logic          r_pwrite;
    logic [AW-1:0] r_paddr;
    logic [DW-1:0] r_pwdata;

    logic          w_win;
    logic [AW-1:0] w_winAddr;
    logic [DW-1:0] w_winWdata;
    logic          w_winWrite;
    logic [CW-1:0] w_cntNext;
    logic          w_timeout;

    // On contention the requester that did not win last time is chosen.
    always_comb begin
        w_win = 1'b0;
        case (req_valid)
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    assign w_winAddr  = w_win ? req_addr[AW +: AW]  : req_addr[0 +: AW];
    assign w_winWdata = w_win ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
    assign w_winWrite = w_win ? req_write[1]        : req_write[0];

    // Abort once this low-PREADY cycle would bring the count up to TIMEOUT.
    assign w_cntNext = r_cnt + CW'(1);
    assign w_timeout = TO_EN && !PREADY && (w_cntNext == TO_LIMIT);

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_cnt      <= '0;
            r_grant    <= 2'b00;
            r_rspValid <= 2'b00;
            r_rspErr   <= 1'b0;
            r_rdata    <= '0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
        end else begin
            r_grant    <= 2'b00;
            r_rspValid <= 2'b00;
            r_rspErr   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid != 2'b00) begin
                        r_state   <= S_SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_grant   <= w_win ? 2'b10 : 2'b01;
                        r_paddr   <= w_winAddr;
                        r_pwrite  <= w_winWrite;
                        r_pwdata  <= w_winWdata;
                        r_last    <= w_win;
                        r_owner   <= w_win;
                    end
                end
                S_SETUP: begin
                    r_state   <= S_ACCESS;
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (PREADY) begin
                        r_state    <= S_IDLE;
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_rspValid <= r_owner ? 2'b10 : 2'b01;
                        r_cnt      <= '0;
                        if (!r_pwrite) begin
                            r_rdata <= PRDATA;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_IDLE;
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_rspValid <= r_owner ? 2'b10 : 2'b01;
                        r_rspErr   <= 1'b1;
                        r_rdata    <= '0;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= w_cntNext;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_cnt     <= '0;
                end
            endcase
        end
    end

    assign req_grant = r_grant;
    assign rsp_valid = r_rspValid;
    assign rsp_err   = r_rspErr;
    assign rsp_rdata = r_rdata;
    assign PSELx     = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule
